// File: rtl/diffout_frame_arb.sv
// Round-robin two-requester framed serial transmitter feeding a differential pad.
// sout carries the logical line bit XOR INV to undo a board-level P/N swap.
module diffout_frame_arb #(
  parameter logic INV   = 1'b0,
  parameter int   NBITS = 16,
  parameter int   GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [NBITS-1:0] dat_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [NBITS-1:0] dat_b,
  output logic             ack_b,
  output logic             busy,
  output logic             sout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t           state, state_n;
  logic [4:0]       cnt, cnt_n;
  logic [3:0]       gcnt, gcnt_n;
  logic [NBITS-1:0] shreg, shreg_n;
  logic             last_b, last_b_n;
  logic             line_n;
  logic             ack_a_n, ack_b_n;
  logic             grant_a;

  // A wins a tie only when B held the previous grant
  assign grant_a = req_a && (!req_b || last_b);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    shreg_n  = shreg;
    last_b_n = last_b;
    line_n   = 1'b0;
    ack_a_n  = 1'b0;
    ack_b_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_a || req_b) begin
          state_n  = S_START;
          line_n   = 1'b1;
          shreg_n  = grant_a ? dat_a : dat_b;
          ack_a_n  = grant_a;
          ack_b_n  = !grant_a;
          last_b_n = !grant_a;
        end
      end
      S_START: begin
        state_n = S_DATA;
        cnt_n   = 5'(NBITS - 1);
        line_n  = shreg[NBITS-1];
      end
      S_DATA: begin
        if (cnt == 5'd0) begin
          state_n = S_STOP;
        end else begin
          cnt_n   = cnt - 5'd1;
          shreg_n = {shreg[NBITS-2:0], 1'b0};
          line_n  = shreg[NBITS-2];
        end
      end
      S_STOP: begin
        if (GAP > 0) begin
          state_n = S_GAP;
          gcnt_n  = 4'(GAP - 1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt == 4'd0) state_n = S_IDLE;
        else gcnt_n = gcnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      shreg  <= '0;
      last_b <= 1'b1;
      sout   <= INV;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      shreg  <= shreg_n;
      last_b <= last_b_n;
      sout   <= line_n ^ INV;
      ack_a  <= ack_a_n;
      ack_b  <= ack_b_n;
      busy   <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_diffout_frame_arb.sv
// Bench for diffout_frame_arb: INV=0 and INV=1 instances share stimulus;
// table vectors, directed sequences and a queue-based frame model.
module tb_diffout_frame_arb;

  localparam int NB = 8;
  localparam int GP = 2;
  localparam int PERIOD = NB + 3 + GP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_a, req_b;
  logic [NB-1:0] dat_a, dat_b;
  logic          ack_a0, ack_b0, busy0, sout0;
  logic          ack_a1, ack_b1, busy1, sout1;

  diffout_frame_arb #(.INV(1'b0), .NBITS(NB), .GAP(GP)) u0 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .dat_a(dat_a), .ack_a(ack_a0),
    .req_b(req_b), .dat_b(dat_b), .ack_b(ack_b0),
    .busy(busy0), .sout(sout0)
  );

  diffout_frame_arb #(.INV(1'b1), .NBITS(NB), .GAP(GP)) u1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .dat_a(dat_a), .ack_a(ack_a1),
    .req_b(req_b), .dat_b(dat_b), .ack_b(ack_b1),
    .busy(busy1), .sout(sout1)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // model: remaining line bits of the current frame after this cycle
  bit m_busy = 1'b0;
  bit m_last_b = 1'b1;
  bit q[$];
  bit e_ack_a, e_ack_b, e_busy, e_line;

  int ack_who[$];
  int ack_at[$];

  function automatic void model_step(bit r, bit ra, bit rb,
                                     logic [NB-1:0] da, logic [NB-1:0] db);
    bit pick_a;
    logic [NB-1:0] d;
    e_ack_a = 1'b0;
    e_ack_b = 1'b0;
    e_line  = 1'b0;
    if (r) begin
      q.delete();
      m_busy   = 1'b0;
      m_last_b = 1'b1;
    end else if (m_busy) begin
      if (q.size() > 0) e_line = q.pop_front();
      else m_busy = 1'b0;
    end else if (ra || rb) begin
      pick_a = ra && (!rb || m_last_b);
      d = pick_a ? da : db;
      q.delete();
      q.push_back(1'b1);
      for (int i = NB - 1; i >= 0; i--) q.push_back(d[i]);
      q.push_back(1'b0);
      for (int i = 0; i < GP; i++) q.push_back(1'b0);
      e_line   = q.pop_front();
      m_busy   = 1'b1;
      m_last_b = !pick_a;
      e_ack_a  = pick_a;
      e_ack_b  = !pick_a;
    end
    e_busy = m_busy;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cycle, got, exp);
    end
  endtask

  task automatic tick();
    bit r  = rst;
    bit ra = req_a;
    bit rb = req_b;
    logic [NB-1:0] da = dat_a;
    logic [NB-1:0] db = dat_b;
    @(posedge clk);
    model_step(r, ra, rb, da, db);
    @(negedge clk);
    cycle++;
    check("model_inv0", 32'({ack_a0, ack_b0, busy0, sout0}),
          32'({e_ack_a, e_ack_b, e_busy, e_line}));
    check("model_inv1", 32'({ack_a1, ack_b1, busy1, sout1}),
          32'({e_ack_a, e_ack_b, e_busy, ~e_line}));
    if (ack_a0) begin ack_who.push_back(0); ack_at.push_back(cycle); end
    if (ack_b0) begin ack_who.push_back(1); ack_at.push_back(cycle); end
  endtask

  task automatic idle(int n);
    req_a = 1'b0;
    req_b = 1'b0;
    rst   = 1'b0;
    repeat (n) tick();
  endtask

  typedef struct {
    bit            r;
    bit            ra;
    bit            rb;
    logic [NB-1:0] da;
    logic [NB-1:0] db;
    logic [3:0]    exp;
  } vec_t;

  vec_t tv[14];
  bit   seq[12];
  int   nb_b;

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    dat_a = '0; dat_b = '0;

    // single A5 frame: ack, start, data MSB-first, stop, gap, idle
    seq = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    tv[0] = '{1, 0, 0, 8'h00, 8'h00, 4'b0000};
    tv[1] = '{0, 1, 0, 8'hA5, 8'h00, 4'b1011};
    for (int i = 2; i < 13; i++)
      tv[i] = '{0, 0, 0, 8'hA5, 8'h00, {3'b001, seq[i-1]}};
    tv[13] = '{0, 0, 0, 8'h00, 8'h00, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].r; req_a = tv[i].ra; req_b = tv[i].rb;
      dat_a = tv[i].da; dat_b = tv[i].db;
      tick();
      check("vec_inv0", 32'({ack_a0, ack_b0, busy0, sout0}), 32'(tv[i].exp));
      check("vec_inv1", 32'({ack_a1, ack_b1, busy1, sout1}),
            32'({tv[i].exp[3:1], ~tv[i].exp[0]}));
    end

    // tie with continuous requests after reset: A,B,A,B every PERIOD
    rst = 1'b1; tick(); rst = 1'b0;
    ack_who.delete(); ack_at.delete();
    req_a = 1'b1; req_b = 1'b1; dat_a = 8'h0F; dat_b = 8'hF0;
    repeat (4 * PERIOD) tick();
    check("rr_count", ack_who.size(), 4);
    for (int i = 0; i < ack_who.size() && i < 4; i++) begin
      check("rr_order", ack_who[i], i % 2);
      if (i > 0) check("rr_spacing", ack_at[i] - ack_at[i-1], PERIOD);
    end

    // lone requester A after its own frame: no starvation wait
    idle(PERIOD + 2);
    ack_who.delete(); ack_at.delete();
    req_a = 1'b1; dat_a = 8'h3C;
    repeat (2 * PERIOD) tick();
    check("solo_count", ack_who.size(), 2);
    for (int i = 0; i < ack_who.size() && i < 2; i++) begin
      check("solo_who", ack_who[i], 0);
      if (i > 0) check("solo_spacing", ack_at[i] - ack_at[i-1], PERIOD);
    end

    // reset during the 4th data bit, then a tie goes to A
    idle(PERIOD + 2);
    req_a = 1'b1; dat_a = 8'h5A;
    tick();
    req_a = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_state", 32'({ack_a0, busy0, sout0, ack_a1, busy1, sout1}),
          32'(6'b000001));
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; dat_b = 8'h99;
    tick();
    check("abort_regrant", 32'({ack_a0, ack_b0, ack_a1, ack_b1}), 32'(4'b1010));

    // B pulses once while busy: never acknowledged
    idle(PERIOD + 2);
    ack_who.delete(); ack_at.delete();
    req_a = 1'b1; dat_a = 8'hC3;
    tick();
    req_a = 1'b0;
    repeat (3) tick();
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    repeat (2 * PERIOD) tick();
    nb_b = 0;
    foreach (ack_who[i]) if (ack_who[i] == 1) nb_b++;
    check("withdrawn_b", nb_b, 0);
    check("withdrawn_a", ack_who.size(), 1);

    // random traffic against the frame model
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      req_a = ($urandom_range(0, 2) == 0);
      req_b = ($urandom_range(0, 2) == 0);
      dat_a = NB'($urandom);
      dat_b = NB'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
